// File: rtl/data_memory_ctrl.sv
// Data memory for the 8-bit datapath: one write and one registered read per cycle.
// After reset a clear sequence zeroes every word, and busy stays high until that sequence ends.
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                addr_err_q, addr_err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [PtrW-1:0]     mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                wr_in, rd_in, wr_ok;
  logic [PtrW-1:0]     wr_idx, rd_idx;

  // Full-width unsigned compare, so high addresses never alias onto low words.
  assign wr_in  = 32'(wr_addr) < DEPTH;
  assign rd_in  = 32'(rd_addr) < DEPTH;
  assign wr_idx = wr_addr[PtrW-1:0];
  assign rd_idx = rd_addr[PtrW-1:0];
  assign wr_ok  = wr_en && wr_in;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        rd_data_d = '0;
        if (ptr_q == PtrW'(DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = StReady;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StReady: begin
        mem_we     = wr_ok;
        mem_waddr  = wr_idx;
        mem_wdata  = wr_data;
        addr_err_d = (wr_en && !wr_in) || (rd_en && !rd_in);
        if (rd_en) begin
          rd_valid_d = 1'b1;
          if (!rd_in) begin
            rd_data_d = '0;
          end else if (wr_ok && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;  // write-first bypass
          end else begin
            rd_data_d = mem[rd_idx];
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array has no reset; the clear state zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == StClear);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: clear timing, read/write paths, range errors and reset.
module tb_data_memory_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  data_memory_ctrl #(
    .DATA_W(8),
    .ADDR_W(8),
    .DEPTH (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Counts edges until busy falls; optionally pokes both ports at clear cycle 10.
  task automatic wait_clear(input bit inject);
    int  cnt  = 0;
    bit  seen = 1'b0;
    do begin
      tick();
      cnt++;
      if (rd_valid || addr_err) seen = 1'b1;
      if (inject && cnt == 10) begin
        wr_en = 1'b1; wr_addr = 8'd3;  wr_data = 8'h55;
        rd_en = 1'b1; rd_addr = 8'd40;
      end else if (inject && cnt == 11) begin
        idle();
      end
    end while (busy && cnt < 100);
    check_eq("clear_len", 32'(cnt), 32);
    check_eq("clear_quiet", 32'(seen), 0);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp_d,
                         input logic exp_err);
    rd_en = 1'b1; rd_addr = a;
    tick();
    check_eq({tag, "_data"}, 32'(rd_data), 32'(exp_d));
    check_eq({tag, "_valid"}, 32'(rd_valid), 1);
    check_eq({tag, "_err"}, 32'(addr_err), 32'(exp_err));
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #1;
    check_eq("rst_busy", 32'(busy), 1);
    check_eq("rst_data", 32'(rd_data), 0);
    check_eq("rst_valid", 32'(rd_valid), 0);
    check_eq("rst_err", 32'(addr_err), 0);
    tick(); tick();
    #2 rst = 1'b0;
    wait_clear(1'b1);

    // Back-to-back reads of every word after clear.
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rd_addr = 8'(i);
      tick();
      check_eq($sformatf("clr_rd%0d", i), {23'd0, rd_valid, rd_data}, 32'h100);
    end
    idle();
    tick();
    check_eq("valid_drop", 32'(rd_valid), 0);

    // Write-first then plain read-back.
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hA5;
    do_read("wf5", 8'd5, 8'hA5, 1'b0);
    wr_en = 1'b0;
    do_read("rd5", 8'd5, 8'hA5, 1'b0);
    tick();
    check_eq("hold_data", 32'(rd_data), 'hA5);

    // Out-of-range write dropped, read returns zero, no aliasing onto 8.
    do_write(8'd40, 8'h3C);
    check_eq("oor_wr_err", 32'(addr_err), 1);
    check_eq("oor_wr_valid", 32'(rd_valid), 0);
    tick();
    check_eq("err_pulse_end", 32'(addr_err), 0);
    do_read("oor40", 8'd40, 8'h00, 1'b1);
    do_read("alias8", 8'd8, 8'h00, 1'b0);

    // Independent read and write in one cycle.
    do_write(8'd3, 8'h77);
    wr_en = 1'b1; wr_addr = 8'd2; wr_data = 8'h11;
    do_read("rw3", 8'd3, 8'h77, 1'b0);
    wr_en = 1'b0;
    do_read("rd2", 8'd2, 8'h11, 1'b0);

    // Boundaries: last legal word and first illegal one, both ports bad together.
    do_write(8'd31, 8'h9C);
    do_read("rd31", 8'd31, 8'h9C, 1'b0);
    wr_en = 1'b1; wr_addr = 8'd32; wr_data = 8'hEE;
    do_read("both_oor", 8'd255, 8'h00, 1'b1);
    wr_en = 1'b0;
    do_read("rd0", 8'd0, 8'h00, 1'b0);

    // Reset in READY with a read result just produced.
    do_write(8'd1, 8'hFF);
    do_read("rd1", 8'd1, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 1);
    check_eq("mid_rst_data", 32'(rd_data), 0);
    check_eq("mid_rst_valid", 32'(rd_valid), 0);
    tick();
    #2 rst = 1'b0;
    wait_clear(1'b0);
    do_read("rd1_cleared", 8'd1, 8'h00, 1'b0);
    do_read("rd5_cleared", 8'd5, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
